// File: rtl/config_cell_multi_context.sv
// Multi-context configuration cell: a serial shift chain holding one mux select
// word per context, with a free-running context counter choosing the live word.
module config_cell_multi_context #(
  parameter int size     = 3,
  parameter int contexts = 4
) (
  input  logic                        CGRA_Clock,
  input  logic                        CGRA_Reset,
  input  logic                        CGRA_Enable,
  input  logic                        Config_Enable,
  input  logic                        ConfigIn,
  output logic                        ConfigOut,
  output logic [size-1:0]             select,
  output logic [$clog2(contexts)-1:0] context_o,
  output logic                        config_valid
);

  localparam int N    = size * contexts;
  localparam int CW   = $clog2(contexts);
  localparam int CNTW = $clog2(N + 2);

  logic [N-1:0]    chain_q,   chain_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  logic            cfg_en_q,  cfg_en_d;
  logic [CW-1:0]   ctx_idx_q, ctx_idx_d;
  logic [size-1:0] active_word;

  // Shift toward bit 0: the first bit of a burst ends in ctx[0] bit 0.
  always_comb begin
    chain_d = chain_q;
    if (Config_Enable) begin
      chain_d = {ConfigIn, chain_q[N-1:1]};
    end
  end

  // Burst length counter saturates one past N so an overrun stays invalid.
  always_comb begin
    cnt_d    = cnt_q;
    cfg_en_d = Config_Enable;
    if (Config_Enable) begin
      if (!cfg_en_q) begin
        cnt_d = CNTW'(1);
      end else if (cnt_q != CNTW'(N + 1)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Loading forces context 0 and wins over execution stepping.
  always_comb begin
    ctx_idx_d = ctx_idx_q;
    if (Config_Enable) begin
      ctx_idx_d = '0;
    end else if (CGRA_Enable) begin
      if (ctx_idx_q == CW'(contexts - 1)) begin
        ctx_idx_d = '0;
      end else begin
        ctx_idx_d = ctx_idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      chain_q   <= '0;
      cnt_q     <= '0;
      cfg_en_q  <= 1'b0;
      ctx_idx_q <= '0;
    end else begin
      chain_q   <= chain_d;
      cnt_q     <= cnt_d;
      cfg_en_q  <= cfg_en_d;
      ctx_idx_q <= ctx_idx_d;
    end
  end

  always_comb begin
    active_word = chain_q[int'(ctx_idx_q) * size +: size];
  end

  assign config_valid = (cnt_q == CNTW'(N));
  assign ConfigOut    = chain_q[0];
  assign context_o    = ctx_idx_q;
  // Mux sees input 0 while loading or when the last burst was the wrong length.
  assign select       = (config_valid && !Config_Enable) ? active_word : '0;

endmodule

// File: tb/tb_config_cell_multi_context.sv
// Directed bench for config_cell_multi_context (size=3, contexts=4, N=12).
module tb_config_cell_multi_context;

  logic       clk;
  logic       rst;
  logic       cgra_en;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_out;
  logic [2:0] select;
  logic [1:0] ctx;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  config_cell_multi_context #(.size(3), .contexts(4)) dut (
    .CGRA_Clock    (clk),
    .CGRA_Reset    (rst),
    .CGRA_Enable   (cgra_en),
    .Config_Enable (cfg_en),
    .ConfigIn      (cfg_in),
    .ConfigOut     (cfg_out),
    .select        (select),
    .context_o     (ctx),
    .config_valid  (valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change #1 after the edge, outputs sampled at #2
  task automatic shift_bit(input logic b);
    cfg_en  = 1'b1;
    cgra_en = 1'b0;
    cfg_in  = b;
    @(posedge clk);
    #1;
    check_eq("sel_gated_while_loading", select, 0);
    cfg_en = 1'b0;
    #1;
  endtask

  task automatic load12(input logic [11:0] w);
    for (int i = 0; i < 12; i++) shift_bit(w[i]);
  endtask

  task automatic step_ctx();
    cgra_en = 1'b1;
    @(posedge clk);
    #1;
    cgra_en = 1'b0;
    #1;
  endtask

  logic [11:0] w1;
  logic [11:0] w2;
  logic [12:0] ov;
  int          exp_ctx[5];

  initial begin
    rst = 1'b0; cgra_en = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    w1 = 12'b001_111_010_101;   // ctx3=1 ctx2=7 ctx1=2 ctx0=5
    w2 = 12'b100_101_110_001;   // ctx3=4 ctx2=5 ctx1=6 ctx0=1
    ov = 13'b1101110010110;     // first bit 0, second bit 1
    exp_ctx = '{1, 2, 3, 0, 1};

    // reset with random inputs
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cgra_en = 1'($urandom_range(0, 1));
      cfg_en  = 1'($urandom_range(0, 1));
      cfg_in  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b0; cgra_en = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    #1;
    check_eq("rst_select", select, 0);
    check_eq("rst_context", ctx, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_cfgout", cfg_out, 0);

    // full load
    load12(w1);
    check_eq("load_valid", valid, 1);
    check_eq("load_select", select, 5);
    check_eq("load_context", ctx, 0);
    check_eq("load_cfgout", cfg_out, 1);

    // context stepping through scoreboard queue
    exp_q.push_back(2); exp_q.push_back(7); exp_q.push_back(1);
    exp_q.push_back(5); exp_q.push_back(2);
    for (int i = 0; i < 5; i++) begin
      step_ctx();
      check_eq("step_context", ctx, exp_ctx[i]);
      check_eq("step_select", select, exp_q.pop_front());
    end

    // overrun and pass-through
    for (int i = 0; i < 12; i++) shift_bit(ov[i]);
    check_eq("ovr_cfgout_after12", cfg_out, 0);
    check_eq("ovr_valid_after12", valid, 1);
    shift_bit(ov[12]);
    check_eq("ovr_valid_after13", valid, 0);
    check_eq("ovr_select_after13", select, 0);
    check_eq("ovr_cfgout_after13", cfg_out, 1);
    check_eq("ovr_context", ctx, 0);
    step_ctx();
    check_eq("ovr_select_stays0", select, 0);

    // reset mid-burst
    for (int i = 0; i < 6; i++) shift_bit(1'b1);
    cfg_en = 1'b1; cfg_in = 1'b1; cgra_en = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cfg_en = 1'b0; cgra_en = 1'b0;
    #1;
    check_eq("midrst_select", select, 0);
    check_eq("midrst_context", ctx, 0);
    check_eq("midrst_valid", valid, 0);
    check_eq("midrst_cfgout", cfg_out, 0);
    load12(w2);
    check_eq("reload_valid", valid, 1);
    check_eq("reload_select", select, 1);
    check_eq("reload_context", ctx, 0);
    step_ctx();
    step_ctx();
    check_eq("reload_ctx2_context", ctx, 2);
    check_eq("reload_ctx2_select", select, 5);

    // simultaneous enables
    cfg_en = 1'b1; cgra_en = 1'b1; cfg_in = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0; cgra_en = 1'b0;
    #1;
    check_eq("both_context", ctx, 0);
    check_eq("both_valid", valid, 0);
    check_eq("both_select", select, 0);
    check_eq("both_cfgout_shifted", cfg_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
